// File: rtl/hpdcache_mem_bridge_if.sv
// rtl/hpdcache_mem_bridge_if.sv - cache-side request/response and memory-bus signals of the bridge
interface hpdcache_mem_bridge_if #(
  parameter int IdWidth = 4
) ();
  logic               rd_req_valid_i;
  logic               rd_req_ready_o;
  logic [31:0]        rd_req_addr_i;
  logic [IdWidth-1:0] rd_req_id_i;
  logic               rd_rsp_valid_o;
  logic               rd_rsp_ready_i;
  logic [31:0]        rd_rsp_data_o;
  logic [IdWidth-1:0] rd_rsp_id_o;
  logic               rd_rsp_last_o;
  logic               wr_req_valid_i;
  logic               wr_req_ready_o;
  logic [31:0]        wr_req_addr_i;
  logic [IdWidth-1:0] wr_req_id_i;
  logic               wr_data_valid_i;
  logic               wr_data_ready_o;
  logic [31:0]        wr_data_i;
  logic [3:0]         wr_be_i;
  logic               wr_last_i;
  logic               wr_rsp_valid_o;
  logic               wr_rsp_ready_i;
  logic [IdWidth-1:0] wr_rsp_id_o;
  logic               wr_rsp_err_o;
  logic               bus_valid_o;
  logic [3:0]         bus_wstrb_o;
  logic [31:0]        bus_addr_o;
  logic [31:0]        bus_wdata_o;
  logic [31:0]        bus_rdata_i;
  logic               bus_ready_i;

  modport slave (
    input  rd_req_valid_i, rd_req_addr_i, rd_req_id_i, rd_rsp_ready_i,
           wr_req_valid_i, wr_req_addr_i, wr_req_id_i,
           wr_data_valid_i, wr_data_i, wr_be_i, wr_last_i, wr_rsp_ready_i,
           bus_rdata_i, bus_ready_i,
    output rd_req_ready_o, rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_id_o, rd_rsp_last_o,
           wr_req_ready_o, wr_data_ready_o, wr_rsp_valid_o, wr_rsp_id_o, wr_rsp_err_o,
           bus_valid_o, bus_wstrb_o, bus_addr_o, bus_wdata_o
  );

  modport master (
    output rd_req_valid_i, rd_req_addr_i, rd_req_id_i, rd_rsp_ready_i,
           wr_req_valid_i, wr_req_addr_i, wr_req_id_i,
           wr_data_valid_i, wr_data_i, wr_be_i, wr_last_i, wr_rsp_ready_i,
           bus_rdata_i, bus_ready_i,
    input  rd_req_ready_o, rd_rsp_valid_o, rd_rsp_data_o, rd_rsp_id_o, rd_rsp_last_o,
           wr_req_ready_o, wr_data_ready_o, wr_rsp_valid_o, wr_rsp_id_o, wr_rsp_err_o,
           bus_valid_o, bus_wstrb_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/hpdcache_mem_bridge.sv
// rtl/hpdcache_mem_bridge.sv - single-outstanding bridge from cache-line read/write ports to a word bus
module hpdcache_mem_bridge #(
  parameter int LineWords = 4,
  parameter int IdWidth   = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  hpdcache_mem_bridge_if.slave io
);
  localparam int               BeatW    = $clog2(LineWords);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(LineWords - 1);

  typedef enum logic [2:0] {IDLE, RD_BUS, RD_RSP, WR_DATA, WR_BUS, WR_RSP} state_e;

  state_e             state_q, state_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  logic [31:0]        base_q, base_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         be_q, be_d;
  logic               err_q, err_d;
  logic               wr_last_q, wr_last_d;
  logic               is_last, rd_grant, wr_grant;

  assign is_last  = (beat_q == LastBeat);
  // A write wins a tie unless the previous transaction was a write; readies stay low under reset.
  assign wr_grant = !reset_i && io.wr_req_valid_i && (!io.rd_req_valid_i || !wr_last_q);
  assign rd_grant = !reset_i && io.rd_req_valid_i && !wr_grant;

  assign io.bus_addr_o    = base_q + {{(30 - BeatW){1'b0}}, beat_q, 2'b00};
  assign io.bus_wdata_o   = data_q;
  assign io.rd_rsp_data_o = data_q;
  assign io.rd_rsp_id_o   = id_q;
  assign io.wr_rsp_id_o   = id_q;
  assign io.wr_rsp_err_o  = err_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      base_q    <= '0;
      id_q      <= '0;
      data_q    <= '0;
      be_q      <= '0;
      err_q     <= 1'b0;
      wr_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      base_q    <= base_d;
      id_q      <= id_d;
      data_q    <= data_d;
      be_q      <= be_d;
      err_q     <= err_d;
      wr_last_q <= wr_last_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    beat_d             = beat_q;
    base_d             = base_q;
    id_d               = id_q;
    data_d             = data_q;
    be_d               = be_q;
    err_d              = err_q;
    wr_last_d          = wr_last_q;
    io.rd_req_ready_o  = 1'b0;
    io.wr_req_ready_o  = 1'b0;
    io.rd_rsp_valid_o  = 1'b0;
    io.rd_rsp_last_o   = 1'b0;
    io.wr_data_ready_o = 1'b0;
    io.wr_rsp_valid_o  = 1'b0;
    io.bus_valid_o     = 1'b0;
    io.bus_wstrb_o     = 4'h0;
    unique case (state_q)
      IDLE: begin
        io.rd_req_ready_o = rd_grant;
        io.wr_req_ready_o = wr_grant;
        if (wr_grant || rd_grant) begin
          base_d    = wr_grant ? (io.wr_req_addr_i & 32'hFFFF_FFFC) : (io.rd_req_addr_i & 32'hFFFF_FFFC);
          id_d      = wr_grant ? io.wr_req_id_i : io.rd_req_id_i;
          beat_d    = '0;
          err_d     = 1'b0;
          wr_last_d = wr_grant;
          state_d   = wr_grant ? WR_DATA : RD_BUS;
        end
      end
      RD_BUS: begin
        io.bus_valid_o = 1'b1;
        if (io.bus_ready_i) begin
          data_d  = io.bus_rdata_i;
          state_d = RD_RSP;
        end
      end
      RD_RSP: begin
        io.rd_rsp_valid_o = 1'b1;
        io.rd_rsp_last_o  = is_last;
        if (io.rd_rsp_ready_i) begin
          state_d = is_last ? IDLE : RD_BUS;
          beat_d  = is_last ? beat_q : beat_q + BeatW'(1);
        end
      end
      WR_DATA: begin
        io.wr_data_ready_o = 1'b1;
        if (io.wr_data_valid_i) begin
          data_d = io.wr_data_i;
          be_d   = io.wr_be_i;
          if (io.wr_last_i != is_last) err_d = 1'b1;
          // An all-zero byte mask completes the beat without a bus access.
          if (io.wr_be_i != 4'h0) state_d = WR_BUS;
          else if (is_last)       state_d = WR_RSP;
          else                    beat_d  = beat_q + BeatW'(1);
        end
      end
      WR_BUS: begin
        io.bus_valid_o = 1'b1;
        io.bus_wstrb_o = be_q;
        if (io.bus_ready_i) begin
          state_d = is_last ? WR_RSP : WR_DATA;
          beat_d  = is_last ? beat_q : beat_q + BeatW'(1);
        end
      end
      WR_RSP: begin
        io.wr_rsp_valid_o = 1'b1;
        if (io.wr_rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_hpdcache_mem_bridge.sv
// tb/tb_hpdcache_mem_bridge.sv - transaction-level self-checking bench for hpdcache_mem_bridge
module tb_hpdcache_mem_bridge;
  localparam int LW = 4;
  localparam int IW = 4;

  typedef struct packed {logic [31:0] addr; logic [IW-1:0] id;} req_t;
  typedef struct packed {logic [31:0] data; logic [3:0] be; logic last;} wd_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata;} bus_t;
  typedef struct packed {logic [31:0] data; logic [IW-1:0] id; logic last;} rrsp_t;
  typedef struct packed {logic [IW-1:0] id; logic err;} wrsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpdcache_mem_bridge_if #(.IdWidth(IW)) bif ();
  hpdcache_mem_bridge #(.LineWords(LW), .IdWidth(IW)) dut (.clk_i(clk), .reset_i(rst), .io(bif));

  int errors = 0;
  int checks = 0;

  req_t  rd_q[$], wr_q[$];
  wd_t   wd_q[$];
  bus_t  exp_bus[$];
  rrsp_t exp_rd[$];
  wrsp_t exp_wr[$];
  logic [31:0]   obs_addr[$], obs_rd_data[$];
  logic [3:0]    obs_strb[$];
  logic [IW-1:0] obs_rd_id[$], obs_wr_id[$];
  bit            obs_rd_last[$], obs_wr_err[$], obs_order[$];

  bit            rd_req_hs, wr_req_hs, wr_data_hs;
  bit            last_wr_served = 1'b0;
  logic [31:0]   wbase;
  logic [IW-1:0] wid;
  int            wk;
  bit            werr;
  int            bus_delay = 0;
  int            bcnt = 0;
  logic [7:0]    rsp_pat = 8'hFF;
  bit            hold_rsp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic any_out();
    return bif.rd_req_ready_o | bif.rd_rsp_valid_o | (|bif.rd_rsp_data_o) | (|bif.rd_rsp_id_o) |
           bif.rd_rsp_last_o | bif.wr_req_ready_o | bif.wr_data_ready_o | bif.wr_rsp_valid_o |
           (|bif.wr_rsp_id_o) | bif.wr_rsp_err_o | bif.bus_valid_o | (|bif.bus_wstrb_o) |
           (|bif.bus_addr_o) | (|bif.bus_wdata_o);
  endfunction

  function automatic bit bench_idle();
    return rd_q.size() == 0 && wr_q.size() == 0 && wd_q.size() == 0 && exp_bus.size() == 0 &&
           exp_rd.size() == 0 && exp_wr.size() == 0 && !bif.rd_req_valid_i && !bif.wr_req_valid_i;
  endfunction

  // Transaction model and per-cycle comparison, sampled mid-low-phase before the next rising edge.
  always begin
    @(negedge clk);
    #2;
    rd_req_hs  = !rst && bif.rd_req_valid_i && bif.rd_req_ready_o;
    wr_req_hs  = !rst && bif.wr_req_valid_i && bif.wr_req_ready_o;
    wr_data_hs = !rst && bif.wr_data_valid_i && bif.wr_data_ready_o;
    if (!rst) begin
      chk("both_req_ready", 32'(bif.rd_req_ready_o & bif.wr_req_ready_o), 32'd0);
      if (bif.bus_valid_o) begin
        if (exp_bus.size() == 0) chk("bus_unexpected_valid", 32'(bif.bus_valid_o), 32'd0);
        else begin
          chk("bus_addr", bif.bus_addr_o, exp_bus[0].addr);
          chk("bus_wstrb", 32'(bif.bus_wstrb_o), 32'(exp_bus[0].wstrb));
          if (exp_bus[0].wstrb != 4'h0) chk("bus_wdata", bif.bus_wdata_o, exp_bus[0].wdata);
          if (bif.bus_ready_i) begin
            obs_addr.push_back(bif.bus_addr_o);
            obs_strb.push_back(bif.bus_wstrb_o);
            void'(exp_bus.pop_front());
          end
        end
      end
      if (bif.rd_rsp_valid_o) begin
        if (exp_rd.size() == 0) chk("rd_rsp_unexpected_valid", 32'(bif.rd_rsp_valid_o), 32'd0);
        else begin
          chk("rd_rsp_data", bif.rd_rsp_data_o, exp_rd[0].data);
          chk("rd_rsp_id", 32'(bif.rd_rsp_id_o), 32'(exp_rd[0].id));
          chk("rd_rsp_last", 32'(bif.rd_rsp_last_o), 32'(exp_rd[0].last));
          if (bif.rd_rsp_ready_i) begin
            obs_rd_data.push_back(bif.rd_rsp_data_o);
            obs_rd_id.push_back(bif.rd_rsp_id_o);
            obs_rd_last.push_back(bif.rd_rsp_last_o);
            void'(exp_rd.pop_front());
          end
        end
      end
      if (bif.wr_rsp_valid_o) begin
        if (exp_wr.size() == 0) chk("wr_rsp_unexpected_valid", 32'(bif.wr_rsp_valid_o), 32'd0);
        else begin
          chk("wr_rsp_id", 32'(bif.wr_rsp_id_o), 32'(exp_wr[0].id));
          chk("wr_rsp_err", 32'(bif.wr_rsp_err_o), 32'(exp_wr[0].err));
          if (bif.wr_rsp_ready_i) begin
            obs_wr_id.push_back(bif.wr_rsp_id_o);
            obs_wr_err.push_back(bif.wr_rsp_err_o);
            void'(exp_wr.pop_front());
          end
        end
      end
      if (rd_req_hs) begin
        if (bif.wr_req_valid_i) chk("arb_read_wins", 32'(last_wr_served), 32'd1);
        last_wr_served = 1'b0;
        obs_order.push_back(1'b0);
        for (int i = 0; i < LW; i++) begin
          logic [31:0] a;
          a = (bif.rd_req_addr_i & 32'hFFFF_FFFC) + 32'(4 * i);
          exp_bus.push_back('{addr: a, wstrb: 4'h0, wdata: 32'h0});
          exp_rd.push_back('{data: mem_word(a), id: bif.rd_req_id_i, last: (i == LW - 1)});
        end
      end
      if (wr_req_hs) begin
        if (bif.rd_req_valid_i) chk("arb_write_wins", 32'(last_wr_served), 32'd0);
        last_wr_served = 1'b1;
        obs_order.push_back(1'b1);
        wbase = bif.wr_req_addr_i & 32'hFFFF_FFFC;
        wid   = bif.wr_req_id_i;
        wk    = 0;
        werr  = 1'b0;
      end
      if (wr_data_hs) begin
        if (bif.wr_be_i != 4'h0)
          exp_bus.push_back('{addr: wbase + 32'(4 * wk), wstrb: bif.wr_be_i, wdata: bif.wr_data_i});
        if (bif.wr_last_i != (wk == LW - 1)) werr = 1'b1;
        wk++;
        if (wk == LW) exp_wr.push_back('{id: wid, err: werr});
      end
    end
  end

  always @(negedge clk) begin
    if (rst) bif.rd_req_valid_i = 1'b0;
    else begin
      if (bif.rd_req_valid_i && rd_req_hs) begin
        bif.rd_req_valid_i = 1'b0;
        void'(rd_q.pop_front());
      end
      if (!bif.rd_req_valid_i && rd_q.size() > 0) begin
        bif.rd_req_valid_i = 1'b1;
        bif.rd_req_addr_i  = rd_q[0].addr;
        bif.rd_req_id_i    = rd_q[0].id;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) bif.wr_req_valid_i = 1'b0;
    else begin
      if (bif.wr_req_valid_i && wr_req_hs) begin
        bif.wr_req_valid_i = 1'b0;
        void'(wr_q.pop_front());
      end
      if (!bif.wr_req_valid_i && wr_q.size() > 0) begin
        bif.wr_req_valid_i = 1'b1;
        bif.wr_req_addr_i  = wr_q[0].addr;
        bif.wr_req_id_i    = wr_q[0].id;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) bif.wr_data_valid_i = 1'b0;
    else begin
      if (bif.wr_data_valid_i && wr_data_hs) begin
        bif.wr_data_valid_i = 1'b0;
        void'(wd_q.pop_front());
      end
      if (!bif.wr_data_valid_i && wd_q.size() > 0) begin
        bif.wr_data_valid_i = 1'b1;
        bif.wr_data_i       = wd_q[0].data;
        bif.wr_be_i         = wd_q[0].be;
        bif.wr_last_i       = wd_q[0].last;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      bif.bus_ready_i = 1'b0;
      bcnt            = 0;
    end else if (bif.bus_valid_o && !bif.bus_ready_i) begin
      if (bcnt >= bus_delay) begin
        bif.bus_ready_i = 1'b1;
        bif.bus_rdata_i = mem_word(bif.bus_addr_o);
        bcnt            = 0;
      end else bcnt++;
    end else begin
      bif.bus_ready_i = 1'b0;
      bif.bus_rdata_i = 32'hBAD0_BAD0;
    end
    rsp_pat            = {rsp_pat[6:0], rsp_pat[7]};
    bif.rd_rsp_ready_i = rsp_pat[0] && !hold_rsp;
    bif.wr_rsp_ready_i = rsp_pat[3];
  end

  task automatic wait_done(input string name);
    for (int c = 0; c < 3000 && !bench_idle(); c++) @(posedge clk);
    chk({name, "_completed"}, 32'(bench_idle()), 32'd1);
  endtask

  task automatic clear_obs();
    obs_addr.delete(); obs_strb.delete(); obs_rd_data.delete(); obs_rd_id.delete();
    obs_rd_last.delete(); obs_wr_id.delete(); obs_wr_err.delete(); obs_order.delete();
  endtask

  task automatic flush_model();
    rd_q.delete(); wr_q.delete(); wd_q.delete();
    exp_bus.delete(); exp_rd.delete(); exp_wr.delete();
    last_wr_served = 1'b0;
    wk = 0;
    werr = 1'b0;
  endtask

  task automatic push_line(input logic [31:0] d0, input logic [3:0] be [4], input bit lastv [4]);
    for (int i = 0; i < 4; i++) wd_q.push_back('{data: d0 + 32'(i), be: be[i], last: lastv[i]});
  endtask

  logic [31:0] e_addr [4];
  logic [3:0]  e_be [4];
  bit          e_last [4];

  initial begin
    bif.rd_req_valid_i = 1'b0; bif.rd_req_addr_i = '0; bif.rd_req_id_i = '0; bif.rd_rsp_ready_i = 1'b0;
    bif.wr_req_valid_i = 1'b0; bif.wr_req_addr_i = '0; bif.wr_req_id_i = '0;
    bif.wr_data_valid_i = 1'b0; bif.wr_data_i = '0; bif.wr_be_i = '0; bif.wr_last_i = 1'b0;
    bif.wr_rsp_ready_i = 1'b0; bif.bus_rdata_i = 32'hBAD0_BAD0; bif.bus_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_outputs_zero", 32'(any_out()), 32'd0);
    bif.rd_req_valid_i = 1'b1; bif.wr_req_valid_i = 1'b1;
    #1 chk("reset_no_req_ready", 32'({bif.rd_req_ready_o, bif.wr_req_ready_o}), 32'd0);
    bif.rd_req_valid_i = 1'b0; bif.wr_req_valid_i = 1'b0;
    @(negedge clk); #3 rst = 1'b0;

    // Read at unaligned address, slow bus, stalled response side
    @(posedge clk); bus_delay = 2; rsp_pat = 8'b1011_0110; clear_obs();
    rd_q.push_back('{addr: 32'h0000_1003, id: 4'd5});
    wait_done("rd_basic");
    e_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    chk("rd_basic_nbus", 32'(obs_addr.size()), 32'd4);
    chk("rd_basic_nrsp", 32'(obs_rd_data.size()), 32'd4);
    if (obs_addr.size() == 4 && obs_rd_data.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rd_basic_addr", obs_addr[i], e_addr[i]);
      chk("rd_basic_last", 32'({obs_rd_last[0], obs_rd_last[1], obs_rd_last[2], obs_rd_last[3]}), 32'b0001);
      chk("rd_basic_data0", obs_rd_data[0], 32'hDEAD_1000);
      chk("rd_basic_data3", obs_rd_data[3], 32'hDEAD_100C);
      chk("rd_basic_id3", 32'(obs_rd_id[3]), 32'd5);
    end

    // Write with a zero-mask beat that must skip the bus
    @(posedge clk); bus_delay = 1; rsp_pat = 8'b1101_1011; clear_obs();
    e_be = '{4'hF, 4'h0, 4'h3, 4'hF}; e_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    wr_q.push_back('{addr: 32'h0000_2000, id: 4'd3});
    push_line(32'hC0DE_0000, e_be, e_last);
    wait_done("wr_skip");
    chk("wr_skip_nbus", 32'(obs_addr.size()), 32'd3);
    chk("wr_skip_nrsp", 32'(obs_wr_err.size()), 32'd1);
    if (obs_addr.size() == 3 && obs_wr_err.size() == 1) begin
      chk("wr_skip_addr0", obs_addr[0], 32'h2000);
      chk("wr_skip_addr1", obs_addr[1], 32'h2008);
      chk("wr_skip_addr2", obs_addr[2], 32'h200C);
      chk("wr_skip_strb1", 32'(obs_strb[1]), 32'h3);
      chk("wr_skip_err", 32'(obs_wr_err[0]), 32'd0);
      chk("wr_skip_id", 32'(obs_wr_id[0]), 32'd3);
    end

    // Framing error on early last, then a clean write clears it
    @(posedge clk); bus_delay = 0; clear_obs();
    e_be = '{4'hF, 4'hF, 4'hF, 4'hF};
    wr_q.push_back('{addr: 32'h0000_2400, id: 4'd6});
    wr_q.push_back('{addr: 32'h0000_2800, id: 4'd7});
    e_last = '{1'b0, 1'b1, 1'b0, 1'b0};
    push_line(32'h1111_0000, e_be, e_last);
    e_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    push_line(32'h2222_0000, e_be, e_last);
    wait_done("wr_frame");
    chk("wr_frame_nbus", 32'(obs_addr.size()), 32'd8);
    chk("wr_frame_nrsp", 32'(obs_wr_err.size()), 32'd2);
    if (obs_wr_err.size() == 2) begin
      chk("wr_frame_err_bad", 32'(obs_wr_err[0]), 32'd1);
      chk("wr_frame_err_clean", 32'(obs_wr_err[1]), 32'd0);
    end

    // Address wrap at the top of the 32-bit space
    @(posedge clk); clear_obs();
    rd_q.push_back('{addr: 32'hFFFF_FFF8, id: 4'd2});
    wait_done("rd_wrap");
    e_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    chk("rd_wrap_nbus", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4 && obs_rd_data.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("rd_wrap_addr", obs_addr[i], e_addr[i]);
      chk("rd_wrap_data2", obs_rd_data[2], 32'hDEAD_0000);
    end

    // Simultaneous requests after reset: write first, then alternation
    @(posedge clk); #2 rst = 1'b1; flush_model();
    repeat (2) @(posedge clk);
    @(negedge clk); #3 rst = 1'b0;
    @(posedge clk); bus_delay = 1; rsp_pat = 8'hFF; clear_obs();
    e_last = '{1'b0, 1'b0, 1'b0, 1'b1};
    rd_q.push_back('{addr: 32'h0000_3000, id: 4'd1});
    rd_q.push_back('{addr: 32'h0000_3100, id: 4'd2});
    wr_q.push_back('{addr: 32'h0000_4000, id: 4'd7});
    wr_q.push_back('{addr: 32'h0000_4100, id: 4'd8});
    push_line(32'h4444_0000, e_be, e_last);
    push_line(32'h5555_0000, e_be, e_last);
    wait_done("arb");
    chk("arb_count", 32'(obs_order.size()), 32'd4);
    if (obs_order.size() == 4)
      chk("arb_order", 32'({obs_order[0], obs_order[1], obs_order[2], obs_order[3]}), 32'b1010);

    // Reset while a read response is stalled, then a normal read
    @(posedge clk); hold_rsp = 1'b1; clear_obs();
    rd_q.push_back('{addr: 32'h0000_5000, id: 4'd9});
    for (int c = 0; c < 200 && !bif.rd_rsp_valid_o; c++) @(posedge clk);
    chk("rst_mid_rsp_seen", 32'(bif.rd_rsp_valid_o), 32'd1);
    @(negedge clk); #3 rst = 1'b1;
    #1 chk("rst_mid_outputs_zero", 32'(any_out()), 32'd0);
    flush_model();
    repeat (3) @(posedge clk);
    #1 chk("rst_hold_outputs_zero", 32'(any_out()), 32'd0);
    @(negedge clk); #3 rst = 1'b0; hold_rsp = 1'b0;
    repeat (4) @(posedge clk);
    chk("rst_mid_no_beats", 32'(obs_rd_data.size()), 32'd0);
    rd_q.push_back('{addr: 32'h0000_6004, id: 4'd10});
    wait_done("rd_after_rst");
    chk("rd_after_rst_nrsp", 32'(obs_rd_data.size()), 32'd4);
    if (obs_rd_data.size() == 4) begin
      chk("rd_after_rst_data0", obs_rd_data[0], 32'hDEAD_6004);
      chk("rd_after_rst_id", 32'(obs_rd_id[0]), 32'd10);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule

// File: doc/hpdcache_mem_bridge.md
HPDCACHE_MEM_BRIDGE -- requirements
Module: hpdcache_mem_bridge

Interface
REQ-001 SHALL have parameter LineWords, default 4, meaning 32-bit beats per cache-line transfer (power of two, 2..16).
REQ-002 SHALL have parameter IdWidth, default 4, meaning transaction ID width.
REQ-003 SHALL have ports: clk_i input 1, clock; reset_i input 1, reset, asynchronous, active-high.
REQ-004 SHALL have read-request ports: rd_req_valid_i in 1, valid; rd_req_ready_o out 1, ready; rd_req_addr_i in 32, line base address; rd_req_id_i in IdWidth, ID.
REQ-005 SHALL have read-response ports: rd_rsp_valid_o out 1, valid; rd_rsp_ready_i in 1, ready; rd_rsp_data_o out 32, beat data; rd_rsp_id_o out IdWidth, ID; rd_rsp_last_o out 1, final beat.
REQ-006 SHALL have write-request ports: wr_req_valid_i in 1, valid; wr_req_ready_o out 1, ready; wr_req_addr_i in 32, line base; wr_req_id_i in IdWidth, ID.
REQ-007 SHALL have write-data ports: wr_data_valid_i in 1, valid; wr_data_ready_o out 1, ready; wr_data_i in 32, data; wr_be_i in 4, byte enables; wr_last_i in 1, final beat.
REQ-008 SHALL have write-response ports: wr_rsp_valid_o out 1, valid; wr_rsp_ready_i in 1, ready; wr_rsp_id_o out IdWidth, ID; wr_rsp_err_o out 1, framing error.
REQ-009 SHALL have memory-bus ports: bus_valid_o out 1, request; bus_wstrb_o out 4, write strobes (0 = read); bus_addr_o out 32, word address; bus_wdata_o out 32, write data; bus_rdata_i in 32, read data; bus_ready_i in 1, transfer done.

Function
REQ-010 SHALL implement FSM states IDLE, RD_BUS, RD_RSP, WR_DATA, WR_BUS, WR_RSP; exactly one transaction in flight.
REQ-011 In IDLE, rd_req_ready_o/wr_req_ready_o SHALL be asserted only for the granted side; both ready never high together; all other readies/valids low.
REQ-012 Arbitration SHALL be round-robin: both pending -> side not served last wins; after reset, write wins first.
REQ-013 On request handshake SHALL latch {addr[31:2],2'b00}, ID, beat counter = 0; read -> RD_BUS, write -> WR_DATA.
REQ-014 bus_addr_o SHALL equal latched base + 4*beat, modulo 2^32 (wrap at 0xFFFF_FFFC -> 0x0000_0000).
REQ-015 Bus rule: bus_valid_o held with addr/wstrb/wdata stable until the cycle bus_ready_i=1; bus_valid_o low the following cycle; bus_ready_i ignored while bus_valid_o=0.
REQ-016 RD_BUS: bus_wstrb_o=0; on bus_ready_i capture bus_rdata_i -> RD_RSP.
REQ-017 RD_RSP: rd_rsp_valid_o=1, data/ID stable, rd_rsp_last_o = (beat==LineWords-1); on rd_rsp_ready_i: last -> IDLE, else beat+1 -> RD_BUS.
REQ-018 Read latency: first rd_rsp_valid_o one cycle after bus_ready_i; no beat dropped or duplicated under arbitrary rd_rsp_ready_i stalls.
REQ-019 WR_DATA: wr_data_ready_o=1; on handshake latch data/be; be!=0 -> WR_BUS; be==0 -> skip bus access, treated as completed beat.
REQ-020 WR_BUS: bus_wstrb_o=latched be; on bus_ready_i: beat==LineWords-1 -> WR_RSP, else beat+1 -> WR_DATA.
REQ-021 Framing error SHALL set when wr_last_i=1 on a non-final beat or 0 on the final beat; transfer still runs exactly LineWords beats; wr_rsp_err_o=flag; flag cleared on next request accept.
REQ-022 WR_RSP: wr_rsp_valid_o=1 with latched ID until wr_rsp_ready_i -> IDLE.
REQ-023 Requests arriving during an active transaction SHALL wait (ready low); no request lost.

Reset
REQ-024 reset_i asserted SHALL immediately force IDLE, beat=0, err=0, RR pointer to write-first, all outputs 0.
REQ-025 Reset mid-transaction SHALL abandon it with no response; bus_valid_o drops without waiting for bus_ready_i.
REQ-026 First request SHALL be accepted no earlier than first rising edge after reset_i deasserts.

Verification
REQ-027 Read addr 0x0000_1003, ID 5, bus_ready 2 cycles after each valid -> bus addrs 0x1000,0x1004,0x1008,0x100C, four responses ID 5, last only on 4th, data matches.
REQ-028 Write 4 beats be=0xF,0x0,0x3,0xF, addr 0x2000, wr_last on beat 4 -> three bus writes (0x2000,0x2008,0x200C), wr_rsp err=0.
REQ-029 Read and write valid same cycle after reset -> write served first, then read; repeated simultaneous -> alternation.
REQ-030 Write with wr_last_i on beat 2 -> still 4 beats consumed, wr_rsp_err_o=1; next write clean -> err=0.
REQ-031 Read at 0xFFFF_FFF8 -> addrs 0xFFFF_FFF8,0xFFFF_FFFC,0x0000_0000,0x0000_0004.
REQ-032 reset_i pulsed during RD_RSP with rd_rsp_ready_i=0 -> all outputs 0 same cycle, no further beats; following read completes normally.
